// File: rtl/lfsr_tap_search.sv
// lfsr_tap_search: sequential search over the nine maximal-length 7-bit tap
// patterns. Each candidate runs the LFSR forward from the latched seed for the
// latched step count and is compared against the observed target value.
// Optional feature macro: LFSR_SEARCH_ALL_EN -- evaluate all nine patterns, report
// the lowest match plus the number of matches and an ambiguity flag.
module lfsr_tap_search (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [6:0] seed,
  input  logic [6:0] target,
  input  logic [3:0] steps,
  output logic       busy,
  output logic       done,
  output logic       found,
  output logic [3:0] tap_idx,
  output logic [6:0] tap_pattern
`ifdef LFSR_SEARCH_ALL_EN
  ,
  output logic [3:0] match_count,
  output logic       ambiguous
`endif
);

  typedef enum logic [2:0] {StIdle, StLoad, StShift, StCmp, StDone} state_e;

  localparam logic [3:0] LastIdx = 4'd8;

  state_e     state_q, state_d;
  logic [6:0] seed_q, seed_d;
  logic [6:0] target_q, target_d;
  logic [3:0] steps_q, steps_d;
  logic [3:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic [6:0] lfsr_q, lfsr_d;
  logic       found_q, found_d;
  logic [3:0] tap_idx_q, tap_idx_d;
  logic [6:0] tap_pattern_q, tap_pattern_d;
`ifdef LFSR_SEARCH_ALL_EN
  logic [3:0] match_count_q, match_count_d;
`endif

  logic [6:0] cur_tap;
  logic       match;

  // Fixed table of maximal-length feedback taps, index 0..8.
  function automatic logic [6:0] tap_of(input logic [3:0] i);
    logic [6:0] t;
    unique case (i)
      4'd0:    t = 7'h60;
      4'd1:    t = 7'h48;
      4'd2:    t = 7'h78;
      4'd3:    t = 7'h72;
      4'd4:    t = 7'h6A;
      4'd5:    t = 7'h69;
      4'd6:    t = 7'h5C;
      4'd7:    t = 7'h7E;
      4'd8:    t = 7'h7B;
      default: t = 7'h00;
    endcase
    return t;
  endfunction

  assign cur_tap = tap_of(idx_q);
  assign match   = (lfsr_q == target_q);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StLoad;
      StLoad:  state_d = (steps_q == 4'd0) ? StCmp : StShift;
      StShift: if (cnt_q == 4'd1) state_d = StCmp;
`ifdef LFSR_SEARCH_ALL_EN
      StCmp:   state_d = (idx_q == LastIdx) ? StDone : StLoad;
`else
      StCmp:   state_d = (match || idx_q == LastIdx) ? StDone : StLoad;
`endif
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Status outputs decoded from the current state.
  always_comb begin
    busy = (state_q != StIdle);
    done = (state_q == StDone);
  end

  // Datapath next-state: operand latch, LFSR stepping and result capture.
  always_comb begin
    seed_d        = seed_q;
    target_d      = target_q;
    steps_d       = steps_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    lfsr_d        = lfsr_q;
    found_d       = found_q;
    tap_idx_d     = tap_idx_q;
    tap_pattern_d = tap_pattern_q;
`ifdef LFSR_SEARCH_ALL_EN
    match_count_d = match_count_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          seed_d        = seed;
          target_d      = target;
          steps_d       = steps;
          idx_d         = 4'd0;
          found_d       = 1'b0;
          tap_idx_d     = 4'd0;
          tap_pattern_d = 7'h00;
`ifdef LFSR_SEARCH_ALL_EN
          match_count_d = 4'd0;
`endif
        end
      end
      StLoad: begin
        lfsr_d = seed_q;
        cnt_d  = steps_q;
      end
      StShift: begin
        lfsr_d = {lfsr_q[5:0], ^(lfsr_q & cur_tap)};
        cnt_d  = cnt_q - 4'd1;
      end
      StCmp: begin
`ifdef LFSR_SEARCH_ALL_EN
        // found_q doubles as "a lower index already matched".
        if (match) begin
          match_count_d = match_count_q + 4'd1;
          if (!found_q) begin
            found_d       = 1'b1;
            tap_idx_d     = idx_q;
            tap_pattern_d = cur_tap;
          end
        end
        if (idx_q == LastIdx) begin
          if (!found_q && !match) begin
            tap_idx_d     = LastIdx;
            tap_pattern_d = 7'h00;
          end
        end else begin
          idx_d = idx_q + 4'd1;
        end
`else
        if (match) begin
          found_d       = 1'b1;
          tap_idx_d     = idx_q;
          tap_pattern_d = cur_tap;
        end else if (idx_q == LastIdx) begin
          found_d       = 1'b0;
          tap_idx_d     = LastIdx;
          tap_pattern_d = 7'h00;
        end else begin
          idx_d = idx_q + 4'd1;
        end
`endif
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seed_q        <= 7'h00;
      target_q      <= 7'h00;
      steps_q       <= 4'd0;
      idx_q         <= 4'd0;
      cnt_q         <= 4'd0;
      lfsr_q        <= 7'h00;
      found_q       <= 1'b0;
      tap_idx_q     <= 4'd0;
      tap_pattern_q <= 7'h00;
`ifdef LFSR_SEARCH_ALL_EN
      match_count_q <= 4'd0;
`endif
    end else begin
      seed_q        <= seed_d;
      target_q      <= target_d;
      steps_q       <= steps_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      lfsr_q        <= lfsr_d;
      found_q       <= found_d;
      tap_idx_q     <= tap_idx_d;
      tap_pattern_q <= tap_pattern_d;
`ifdef LFSR_SEARCH_ALL_EN
      match_count_q <= match_count_d;
`endif
    end
  end

  assign found       = found_q;
  assign tap_idx     = tap_idx_q;
  assign tap_pattern = tap_pattern_q;
`ifdef LFSR_SEARCH_ALL_EN
  assign match_count = match_count_q;
  assign ambiguous   = (match_count_q > 4'd1);
`endif

endmodule

// File: tb/tb_lfsr_tap_search.sv
// Self-checking bench for lfsr_tap_search: a reference model computes the
// expected result and Done cycle when a search is started; a monitor pops and
// compares when Done is seen.
module tb_lfsr_tap_search;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [6:0] seed;
  logic [6:0] target;
  logic [3:0] steps;
  logic       busy;
  logic       done;
  logic       found;
  logic [3:0] tap_idx;
  logic [6:0] tap_pattern;
`ifdef LFSR_SEARCH_ALL_EN
  logic [3:0] match_count;
  logic       ambiguous;
`endif

  lfsr_tap_search dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .seed       (seed),
    .target     (target),
    .steps      (steps),
    .busy       (busy),
    .done       (done),
    .found      (found),
    .tap_idx    (tap_idx),
`ifdef LFSR_SEARCH_ALL_EN
    .tap_pattern(tap_pattern),
    .match_count(match_count),
    .ambiguous  (ambiguous)
`else
    .tap_pattern(tap_pattern)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        found;
    logic [3:0]  idx;
    logic [6:0]  pat;
    logic [3:0]  cnt;
    logic [31:0] cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [6:0]  taps [9] = '{7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B};
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // Reference: run every pattern, keep the lowest match and the match count.
  function automatic exp_t model(input logic [6:0] s0, input logic [6:0] t, input logic [3:0] n);
    exp_t       e;
    logic [6:0] s;
    e = '0;
    e.idx = 4'd8;
    for (int i = 0; i < 9; i++) begin
      s = s0;
      for (int k = 0; k < int'(n); k++) s = {s[5:0], ^(s & taps[i])};
      if (s == t) begin
        if (!e.found) begin
          e.found = 1'b1;
          e.idx   = 4'(i);
          e.pat   = taps[i];
        end
        e.cnt = e.cnt + 4'd1;
      end
    end
`ifdef LFSR_SEARCH_ALL_EN
    e.cyc = 9 * (32'(n) + 2) + 1;
`else
    e.cyc = e.found ? (32'(e.idx) + 1) * (32'(n) + 2) + 1 : 9 * (32'(n) + 2) + 1;
`endif
    return e;
  endfunction

  // Monitor: cycle count since Busy rose, scoreboard compare on Done.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cyc = 0;
      end else begin
        if (busy) cyc++;
        else cyc = 0;
        if (done) begin
          if (exp_q.size() == 0) begin
            chk("spurious_done", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("done_cycle", cyc, e.cyc);
            chk("found", 32'(found), 32'(e.found));
            chk("tap_idx", 32'(tap_idx), 32'(e.idx));
            chk("tap_pattern", 32'(tap_pattern), 32'(e.pat));
`ifdef LFSR_SEARCH_ALL_EN
            chk("match_count", 32'(match_count), 32'(e.cnt));
            chk("ambiguous", 32'(ambiguous), 32'(e.cnt > 4'd1));
`endif
          end
        end
      end
    end
  end

  task automatic wait_idle();
    @(negedge clk);
    for (int i = 0; i < 400 && busy; i++) @(negedge clk);
    if (busy) chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  // Start one search; inputs are scrambled after the accepting edge.
  task automatic start_search(input logic [6:0] s, input logic [6:0] t, input logic [3:0] n);
    wait_idle();
    seed   = s;
    target = t;
    steps  = n;
    start  = 1'b1;
    exp_q.push_back(model(s, t, n));
    @(posedge clk);
    #1;
    start  = 1'b0;
    seed   = 7'($urandom);
    target = 7'($urandom);
    steps  = 4'($urandom);
  endtask

  task automatic wait_all();
    for (int i = 0; i < 2000 && (exp_q.size() != 0 || busy); i++) @(negedge clk);
    if (exp_q.size() != 0) chk("result_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_found"}, 32'(found), 32'd0);
    chk({tag, "_tap_idx"}, 32'(tap_idx), 32'd0);
    chk({tag, "_tap_pattern"}, 32'(tap_pattern), 32'd0);
`ifdef LFSR_SEARCH_ALL_EN
    chk({tag, "_match_count"}, 32'(match_count), 32'd0);
    chk({tag, "_ambiguous"}, 32'(ambiguous), 32'd0);
`endif
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    seed   = 7'h00;
    target = 7'h00;
    steps  = 4'd0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Directed vectors.
    start_search(7'h01, 7'h02, 4'd1);
    start_search(7'h01, 7'h03, 4'd1);
    start_search(7'h01, 7'h7F, 4'd1);
    start_search(7'h55, 7'h55, 4'd0);
    start_search(7'h00, 7'h00, 4'd15);
    start_search(7'h00, 7'h11, 4'd3);
    wait_all();

    // Random vectors.
    for (int i = 0; i < 6; i++) start_search(7'($urandom), 7'($urandom), 4'($urandom));
    wait_all();

    // Start pulse while busy must be ignored.
    start_search(7'h01, 7'h7F, 4'd2);
    repeat (4) @(negedge clk);
    seed   = 7'h55;
    target = 7'h55;
    steps  = 4'd0;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    wait_all();
    repeat (3) @(negedge clk);
    chk("ignored_start_idle", 32'(busy), 32'd0);

    // Reset in cycle 10 of a search aborts with no Done.
    start_search(7'h01, 7'h7F, 4'd1);
    repeat (10) @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    start_search(7'h01, 7'h03, 4'd1);
    wait_all();

    // Start held high: back-to-back searches with a single idle cycle.
    wait_idle();
    seed   = 7'h01;
    target = 7'h03;
    steps  = 4'd1;
    start  = 1'b1;
    exp_q.push_back(model(7'h01, 7'h03, 4'd1));
    exp_q.push_back(model(7'h01, 7'h03, 4'd1));
    for (int i = 0; i < 200 && !done; i++) @(negedge clk);
    chk("b2b_first_done", 32'(done), 32'd1);
    @(negedge clk);
    chk("b2b_gap_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("b2b_restart_busy", 32'(busy), 32'd1);
    start = 1'b0;
    wait_all();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
